// File: rtl/adc_sampler_if.sv
// rtl/adc_sampler_if.sv - ADC handshake and downstream sample stream bundle for adc_sampler
interface adc_sampler_if #(
    parameter int DATA_W  = 11,
    parameter int LEVEL_W = 4
);
    logic [DATA_W-1:0]  i_adc_data;
    logic               i_adc_data_rdy;
    logic               i_adc_busy;
    logic               o_adc_convst;
    logic               o_adc_en;
    logic [DATA_W-1:0]  o_sample;
    logic               o_sample_valid;
    logic               i_sample_ready;
    logic [LEVEL_W-1:0] o_fifo_level;

    modport master (
        input  i_adc_data, i_adc_data_rdy, i_adc_busy, i_sample_ready,
        output o_adc_convst, o_adc_en, o_sample, o_sample_valid, o_fifo_level
    );

    modport slave (
        output i_adc_data, i_adc_data_rdy, i_adc_busy, i_sample_ready,
        input  o_adc_convst, o_adc_en, o_sample, o_sample_valid, o_fifo_level
    );
endinterface

// File: rtl/adc_sampler.sv
// rtl/adc_sampler.sv - fixed-rate ADC conversion sequencer with FWFT capture FIFO and sticky error flags
module adc_sampler #(
    parameter int CLK_FREQ_HZ    = 100_000_000,
    parameter int SAMPLE_RATE_HZ = 360,
    parameter int DATA_W         = 11,
    parameter int CONVST_W       = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic          i_clk_100MHz,
    input  logic          i_nrst,
    input  logic          i_enable,
    input  logic          i_clr_flags,
    adc_sampler_if.master bus,
    output logic          o_overflow,
    output logic          o_missed,
    output logic          o_timeout
);
    localparam int DIV    = CLK_FREQ_HZ / SAMPLE_RATE_HZ;
    localparam int CNT_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int PCNT_W = (CONVST_W > 1) ? $clog2(CONVST_W) : 1;
    localparam int WCNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int LW     = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_CONV, S_WAIT} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [PCNT_W-1:0]   pcnt_q, pcnt_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic                convst_q, convst_d;
    logic                adc_en_q, adc_en_d;
    logic                tick, handshake, timeout_evt, missed_evt;

    logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]       level_q, level_d;
    logic                valid_q;
    logic                pop, push_ok, ovf_evt;
    logic                overflow_q, missed_q, timeout_q;
    logic                unused_busy;

    assign unused_busy = bus.i_adc_busy;

    assign tick       = i_enable && (cnt_q == CNT_W'(DIV - 1));
    assign handshake  = adc_en_q && bus.i_adc_data_rdy;
    assign missed_evt = tick && (state_q != S_IDLE);

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!i_enable || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge i_clk_100MHz or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            pcnt_q   <= '0;
            wcnt_q   <= '0;
            convst_q <= 1'b0;
            adc_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pcnt_q   <= pcnt_d;
            wcnt_q   <= wcnt_d;
            convst_q <= convst_d;
            adc_en_q <= adc_en_d;
        end
    end

    // A handshake still completes in the cycle enable drops, since o_adc_en was high.
    always_comb begin
        state_d     = state_q;
        pcnt_d      = pcnt_q;
        wcnt_d      = wcnt_q;
        timeout_evt = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                pcnt_d = '0;
                wcnt_d = '0;
                if (tick) state_d = S_CONV;
            end
            S_CONV: begin
                if (!i_enable) begin
                    state_d = S_IDLE;
                    pcnt_d  = '0;
                end else if (pcnt_q == PCNT_W'(CONVST_W - 1)) begin
                    state_d = S_WAIT;
                    pcnt_d  = '0;
                    wcnt_d  = '0;
                end else begin
                    pcnt_d = pcnt_q + PCNT_W'(1);
                end
            end
            S_WAIT: begin
                if (handshake || !i_enable) begin
                    state_d = S_IDLE;
                    wcnt_d  = '0;
                end else if (wcnt_q == WCNT_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout_evt = 1'b1;
                    state_d     = S_IDLE;
                    wcnt_d      = '0;
                end else begin
                    wcnt_d = wcnt_q + WCNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        convst_d = (state_d == S_CONV);
        adc_en_d = (state_d == S_WAIT);
    end

    // A full FIFO still takes a push when the head is popped in the same cycle.
    assign pop     = valid_q && bus.i_sample_ready;
    assign push_ok = handshake && ((level_q != LW'(FIFO_DEPTH)) || pop);
    assign ovf_evt = handshake && !push_ok;

    always_comb begin
        level_d = level_q;
        if (push_ok && !pop) begin
            level_d = level_q + LW'(1);
        end else if (!push_ok && pop) begin
            level_d = level_q - LW'(1);
        end
    end

    always_ff @(posedge i_clk_100MHz or negedge i_nrst) begin
        if (!i_nrst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
            missed_q   <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= bus.i_adc_data;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            level_q    <= level_d;
            valid_q    <= (level_d != '0);
            overflow_q <= ovf_evt     || (overflow_q && !i_clr_flags);
            missed_q   <= missed_evt  || (missed_q   && !i_clr_flags);
            timeout_q  <= timeout_evt || (timeout_q  && !i_clr_flags);
        end
    end

    assign bus.o_adc_convst   = convst_q;
    assign bus.o_adc_en       = adc_en_q;
    assign bus.o_sample       = mem_q[rd_ptr_q];
    assign bus.o_sample_valid = valid_q;
    assign bus.o_fifo_level   = level_q;
    assign o_overflow         = overflow_q;
    assign o_missed           = missed_q;
    assign o_timeout          = timeout_q;
endmodule

// File: tb/tb_adc_sampler.sv
// tb/tb_adc_sampler.sv - directed/random bench for adc_sampler against a queue-based reference model
module tb_adc_sampler;
    localparam int DATA_W   = 11;
    localparam int CONVST_W = 2;
    localparam int TIMEOUT  = 16;
    localparam int DEPTH    = 4;
    localparam int LW       = 3;
    localparam int PERIOD   = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b0;
    logic clr = 1'b0;
    logic o_overflow, o_missed, o_timeout;

    adc_sampler_if #(.DATA_W(DATA_W), .LEVEL_W(LW)) ifc ();

    adc_sampler #(
        .CLK_FREQ_HZ(1000), .SAMPLE_RATE_HZ(100), .DATA_W(DATA_W),
        .CONVST_W(CONVST_W), .TIMEOUT_CYCLES(TIMEOUT), .FIFO_DEPTH(DEPTH)
    ) dut (
        .i_clk_100MHz(clk), .i_nrst(rst_n), .i_enable(enable), .i_clr_flags(clr),
        .bus(ifc), .o_overflow(o_overflow), .o_missed(o_missed), .o_timeout(o_timeout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int n_hs = 0;
    int resp_delay = -1;
    int en_age = 0;
    int en_rise = 0;
    int cv_rise = 0;
    int to_rise = -1;
    bit prev_en = 1'b0;
    bit prev_cv = 1'b0;
    bit chk_pulse = 1'b1;
    bit pop_on_hs = 1'b0;
    bit clr_on_miss = 1'b0;
    bit exp_ovf = 1'b0;
    logic [DATA_W-1:0] data_q[$];
    logic [DATA_W-1:0] model_q[$];
    logic [DATA_W-1:0] popped[$];
    logic [DATA_W-1:0] snap[$];
    int cv_rises[$];
    logic [DATA_W-1:0] exp1 [3] = '{11'h155, 11'h2AA, 11'h7FF};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_convst"}, ifc.o_adc_convst, 0);
        chk({tag, "_adc_en"}, ifc.o_adc_en, 0);
        chk({tag, "_valid"}, ifc.o_sample_valid, 0);
        chk({tag, "_level"}, ifc.o_fifo_level, 0);
        chk({tag, "_sample"}, ifc.o_sample, 0);
        chk({tag, "_flags"}, {o_overflow, o_missed, o_timeout}, 0);
    endtask

    // One clock: update the reference FIFO from this cycle's handshake/pop, advance, check, drive the ADC.
    task automatic step();
        bit hs, pop, acc, drop;
        hs   = ifc.o_adc_en && ifc.i_adc_data_rdy;
        pop  = (model_q.size() != 0) && ifc.i_sample_ready;
        acc  = (model_q.size() < DEPTH) || pop;
        drop = hs && !acc;
        if (pop) popped.push_back(model_q.pop_front());
        if (hs) begin
            n_hs++;
            if (acc) model_q.push_back(ifc.i_adc_data);
        end
        exp_ovf = drop || (exp_ovf && !clr);

        @(posedge clk);
        #1;
        cyc++;

        chk("level", ifc.o_fifo_level, model_q.size());
        chk("valid", ifc.o_sample_valid, model_q.size() != 0);
        if (model_q.size() != 0) chk("sample", ifc.o_sample, model_q[0]);
        chk("overflow", o_overflow, exp_ovf);

        if (ifc.o_adc_convst && !prev_cv) begin
            cv_rise = cyc;
            cv_rises.push_back(cyc);
        end
        if (!ifc.o_adc_convst && prev_cv && chk_pulse) chk("convst_width", cyc - cv_rise, CONVST_W);
        if (ifc.o_adc_en && !prev_en) begin
            en_rise = cyc;
            en_age  = 0;
            if (chk_pulse) chk("en_after_convst", cyc - cv_rise, CONVST_W);
        end else if (ifc.o_adc_en) begin
            en_age++;
        end
        if (o_timeout && to_rise < 0) to_rise = cyc;
        prev_cv = ifc.o_adc_convst;
        prev_en = ifc.o_adc_en;

        ifc.i_adc_data_rdy = ifc.o_adc_en && (resp_delay >= 0) && (en_age == resp_delay);
        if (ifc.i_adc_data_rdy && data_q.size() != 0) ifc.i_adc_data = data_q.pop_front();
        else ifc.i_adc_data = DATA_W'($urandom);
        ifc.i_adc_busy = 1'($urandom);
        if (pop_on_hs) ifc.i_sample_ready = ifc.i_adc_data_rdy;
        clr = clr_on_miss && ifc.o_adc_en && (en_age == 7);
    endtask

    task automatic wait_hs(input int target, input int budget, input string tag);
        int k = 0;
        while (n_hs < target && k < budget) begin
            step();
            k++;
        end
        chk(tag, n_hs >= target, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, er0, er1, k;
        ifc.i_adc_data     = '0;
        ifc.i_adc_data_rdy = 1'b0;
        ifc.i_adc_busy     = 1'b0;
        ifc.i_sample_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;

        // Periodic sampling with fixed data
        resp_delay = 3;
        data_q = '{11'h155, 11'h2AA, 11'h7FF};
        ifc.i_sample_ready = 1'b1;
        enable = 1'b1;
        c0 = cyc;
        wait_hs(n_hs + 3, 60, "s1_hs");
        repeat (2) step();
        chk("s1_first_tick", cv_rises[0] - c0, PERIOD);
        chk("s1_gap01", cv_rises[1] - cv_rises[0], PERIOD);
        chk("s1_gap12", cv_rises[2] - cv_rises[1], PERIOD);
        chk("s1_npop", popped.size(), 3);
        for (int i = 0; i < 3; i++) chk("s1_order", popped[i], exp1[i]);
        chk("s1_flags", {o_overflow, o_missed, o_timeout}, 0);

        // FIFO full and overflow
        ifc.i_sample_ready = 1'b0;
        wait_hs(n_hs + 5, 70, "s2_hs");
        chk("s2_level_full", ifc.o_fifo_level, DEPTH);
        chk("s2_overflow", o_overflow, 1);
        snap = model_q;
        enable = 1'b0;
        popped.delete();
        ifc.i_sample_ready = 1'b1;
        repeat (6) step();
        chk("s2_npop", popped.size(), DEPTH);
        for (int i = 0; i < DEPTH; i++) chk("s2_order", popped[i], snap[i]);
        chk("s2_level_empty", ifc.o_fifo_level, 0);
        clr = 1'b1;
        step();
        chk("s2_ovf_cleared", o_overflow, 0);

        // Push and pop in the same cycle while full
        ifc.i_sample_ready = 1'b0;
        enable = 1'b1;
        wait_hs(n_hs + 4, 60, "s3_fill");
        chk("s3_level_full", ifc.o_fifo_level, DEPTH);
        pop_on_hs = 1'b1;
        wait_hs(n_hs + 1, 20, "s3_hs");
        pop_on_hs = 1'b0;
        ifc.i_sample_ready = 1'b0;
        chk("s3_level_kept", ifc.o_fifo_level, DEPTH);
        chk("s3_no_overflow", o_overflow, 0);
        enable = 1'b0;
        ifc.i_sample_ready = 1'b1;
        repeat (6) step();
        chk("s3_drained", ifc.o_fifo_level, 0);

        // Timeout with one sample held in the FIFO
        ifc.i_sample_ready = 1'b0;
        enable = 1'b1;
        wait_hs(n_hs + 1, 20, "s4_prefill");
        resp_delay = -1;
        to_rise = -1;
        er0 = en_rise;
        k = 0;
        while (to_rise < 0 && k < 40) begin
            step();
            k++;
        end
        chk("s4_timeout_seen", to_rise >= 0, 1);
        chk("s4_new_wait", en_rise != er0, 1);
        chk("s4_timeout_latency", to_rise - en_rise, TIMEOUT);
        chk("s4_en_dropped", ifc.o_adc_en, 0);
        chk("s4_missed_in_wait", o_missed, 1);
        chk("s4_fifo_kept", ifc.o_fifo_level, 1);
        er1 = en_rise;
        k = 0;
        while (en_rise == er1 && k < 30) begin
            step();
            k++;
        end
        chk("s4_next_conv", en_rise - er1, 2 * PERIOD);
        enable = 1'b0;
        step();
        clr = 1'b1;
        step();
        chk("s4_flags_cleared", {o_missed, o_timeout}, 0);
        ifc.i_sample_ready = 1'b1;
        repeat (3) step();

        // Missed tick and set-wins-over-clear
        resp_delay = 12;
        enable = 1'b1;
        wait_hs(n_hs + 1, 40, "s5_hs");
        chk("s5_missed", o_missed, 1);
        chk("s5_no_timeout", o_timeout, 0);
        clr_on_miss = 1'b1;
        k = 0;
        while (!clr && k < 40) begin
            step();
            k++;
        end
        clr_on_miss = 1'b0;
        chk("s5_clr_reached", clr, 1);
        step();
        chk("s5_set_wins", o_missed, 1);
        enable = 1'b0;
        step();
        clr = 1'b1;
        step();
        chk("s5_missed_cleared", o_missed, 0);

        // Disable during WAIT, then asynchronous reset during CONV
        ifc.i_sample_ready = 1'b0;
        resp_delay = 3;
        enable = 1'b1;
        wait_hs(n_hs + 1, 40, "s6_prefill");
        resp_delay = -1;
        k = 0;
        while (!ifc.o_adc_en && k < 30) begin
            step();
            k++;
        end
        repeat (2) step();
        enable = 1'b0;
        step();
        chk("s6_en_drop", ifc.o_adc_en, 0);
        chk("s6_convst_low", ifc.o_adc_convst, 0);
        chk("s6_level_kept", ifc.o_fifo_level, 1);
        chk("s6_valid_kept", ifc.o_sample_valid, 1);
        repeat (3) step();
        enable = 1'b1;
        k = 0;
        while (!ifc.o_adc_convst && k < 20) begin
            step();
            k++;
        end
        chk("s6_in_conv", ifc.o_adc_convst, 1);
        #3 rst_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        model_q.delete();
        exp_ovf = 1'b0;
        prev_cv = 1'b0;
        prev_en = 1'b0;
        enable = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) step();
        chk("s6_empty_after_reset", ifc.o_fifo_level, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
